// File: rtl/vga_sync_640_480_pkg.sv
// Shared timing constants and phase encodings for the 640x480@60 Hz raster.
// The default parameters of the top level and of the phase FSMs come from here.
// Both axes use the same four-phase encoding.
package vga_sync_640_480_pkg;

  // Horizontal timing, in pixels
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Phase order within a line or frame; BACK wraps to ACTIVE
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_sync_640_480_phase_fsm.sv
// Four-phase sequencer (ACTIVE/FRONT/SYNC/BACK) with a per-phase down-counter.
// o_state is the state register itself; o_wrap flags the last step of BACK.
// Advances only when i_step is high; reset forces ACTIVE with a full count.
module vga_phase_fsm
  import vga_sync_640_480_pkg::*;
#(
  parameter int LEN_ACTIVE = VGA_H_ACTIVE,
  parameter int LEN_FRONT  = VGA_H_FP,
  parameter int LEN_SYNC   = VGA_H_SYNC,
  parameter int LEN_BACK   = VGA_H_BP,
  parameter int CNT_W      = 10
) (
  input  logic   clk,
  input  logic   i_sclr_n,
  input  logic   i_step,
  output phase_e o_state,
  output logic   o_wrap
);

  phase_e             r_state;
  phase_e             w_state_nxt;
  logic [CNT_W-1:0]   r_left;
  logic [CNT_W-1:0]   w_left_nxt;
  logic               w_last;

  // Length of each phase, in steps
  function automatic logic [CNT_W-1:0] phase_len(input phase_e s);
    logic [CNT_W-1:0] len;
    unique case (s)
      PH_ACTIVE: len = CNT_W'(LEN_ACTIVE);
      PH_FRONT:  len = CNT_W'(LEN_FRONT);
      PH_SYNC:   len = CNT_W'(LEN_SYNC);
      PH_BACK:   len = CNT_W'(LEN_BACK);
    endcase
    return len;
  endfunction

  // r_left counts the steps remaining in the current phase, including this one
  assign w_last = (r_left == CNT_W'(1));

  // State register: phase and remaining count, held while i_step is low
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_state <= PH_ACTIVE;
      r_left  <= CNT_W'(LEN_ACTIVE);
    end else if (i_step) begin
      r_state <= w_state_nxt;
      r_left  <= w_left_nxt;
    end
  end

  // Next state: move to the following phase once the current one is used up
  always_comb begin
    w_state_nxt = r_state;
    w_left_nxt  = r_left - CNT_W'(1);
    if (w_last) begin
      unique case (r_state)
        PH_ACTIVE: w_state_nxt = PH_FRONT;
        PH_FRONT:  w_state_nxt = PH_SYNC;
        PH_SYNC:   w_state_nxt = PH_BACK;
        PH_BACK:   w_state_nxt = PH_ACTIVE;
      endcase
      w_left_nxt = phase_len(w_state_nxt);
    end
  end

  // Outputs: registered state, and the end-of-period flag for the next axis
  always_comb begin
    o_state = r_state;
    o_wrap  = (r_state == PH_BACK) && w_last;
  end

endmodule

// File: rtl/vga_sync_640_480.sv
// 640x480@60 raster timing: pixel/line counters, syncs, enables, frame strobe.
// Outputs are register-driven and move on the clk edge that samples i_px_clk=1.
// No backpressure; i_px_clk=0 freezes everything except the 1-cycle frame strobe.
module vga_sync_640_480
  import vga_sync_640_480_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  input  logic       i_px_clk,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_haddr_enb,
  output logic       o_vaddr_enb,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_frame_en,
  output logic [9:0] o_vcnt
);

  phase_e     w_hstate;
  phase_e     w_vstate;
  logic       w_hwrap;
  logic       w_vwrap;
  logic       w_vstep;
  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       r_frame_en;

  // The vertical axis steps once per completed line
  assign w_vstep = i_px_clk & w_hwrap;

  vga_phase_fsm #(
    .LEN_ACTIVE(H_ACTIVE), .LEN_FRONT(H_FP), .LEN_SYNC(H_SYNC), .LEN_BACK(H_BP), .CNT_W(10)
  ) u_hfsm (
    .clk      (clk),
    .i_sclr_n (i_sclr_n),
    .i_step   (i_px_clk),
    .o_state  (w_hstate),
    .o_wrap   (w_hwrap)
  );

  vga_phase_fsm #(
    .LEN_ACTIVE(V_ACTIVE), .LEN_FRONT(V_FP), .LEN_SYNC(V_SYNC), .LEN_BACK(V_BP), .CNT_W(10)
  ) u_vfsm (
    .clk      (clk),
    .i_sclr_n (i_sclr_n),
    .i_step   (w_vstep),
    .o_state  (w_vstate),
    .o_wrap   (w_vwrap)
  );

  // Raster position: hcnt wraps with the horizontal FSM, vcnt with the vertical one
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (i_px_clk) begin
      if (w_hwrap) begin
        r_hcnt <= '0;
        r_vcnt <= w_vwrap ? 10'd0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
    end
  end

  // Frame strobe: one clk on the tick that leaves the last visible line,
  // deliberately not held when i_px_clk drops so it stays one cycle wide
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_frame_en <= 1'b0;
    end else begin
      r_frame_en <= w_vstep && (r_vcnt == 10'(V_ACTIVE - 1));
    end
  end

  // Output decode from the state and counter registers
  always_comb begin
    o_haddr_enb = (w_hstate == PH_ACTIVE);
    o_vaddr_enb = (w_vstate == PH_ACTIVE);
    o_hsync     = ~(w_hstate == PH_SYNC);
    o_vsync     = ~(w_vstate == PH_SYNC);
    o_hidx      = r_hcnt;
    o_vcnt      = r_vcnt;
    o_vidx      = r_vcnt[8:0];
    o_frame_en  = r_frame_en;
  end

endmodule

// File: tb/tb_vga_sync_640_480.sv
// Self-checking bench: full-size 640x480 instance plus a scaled-down instance
// so whole frames (vsync, frame strobe, frame wrap) fit in a short run.
// Both share stimulus and are compared every cycle to a position model.
module tb_vga_sync_640_480;

  logic       clk = 1'b0;
  logic       i_sclr_n;
  logic       i_px_clk;

  logic       a_hsync, a_vsync, a_haddr_enb, a_vaddr_enb, a_frame_en;
  logic [9:0] a_hidx, a_vcnt;
  logic [8:0] a_vidx;
  logic       b_hsync, b_vsync, b_haddr_enb, b_vaddr_enb, b_frame_en;
  logic [9:0] b_hidx, b_vcnt;
  logic [8:0] b_vidx;

  always #5 clk = ~clk;

  vga_sync_640_480 u_dut_a (
    .clk(clk), .i_sclr_n(i_sclr_n), .i_px_clk(i_px_clk),
    .o_hsync(a_hsync), .o_vsync(a_vsync), .o_haddr_enb(a_haddr_enb), .o_vaddr_enb(a_vaddr_enb),
    .o_hidx(a_hidx), .o_vidx(a_vidx), .o_frame_en(a_frame_en), .o_vcnt(a_vcnt)
  );

  vga_sync_640_480 #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(3), .V_SYNC(2), .V_BP(4)
  ) u_dut_b (
    .clk(clk), .i_sclr_n(i_sclr_n), .i_px_clk(i_px_clk),
    .o_hsync(b_hsync), .o_vsync(b_vsync), .o_haddr_enb(b_haddr_enb), .o_vaddr_enb(b_vaddr_enb),
    .o_hidx(b_hidx), .o_vidx(b_vidx), .o_frame_en(b_frame_en), .o_vcnt(b_vcnt)
  );

  // Timing of each instance: index 0 = full size, 1 = scaled
  int p_ha[2]  = '{640, 16};
  int p_hfp[2] = '{16, 4};
  int p_hs[2]  = '{96, 6};
  int p_hbp[2] = '{48, 6};
  int p_va[2]  = '{480, 12};
  int p_vfp[2] = '{10, 3};
  int p_vs[2]  = '{2, 2};
  int p_vbp[2] = '{33, 4};

  // Reference raster position
  int m_h[2];
  int m_v[2];
  bit m_fe[2];

  int n_tests = 0;
  int n_fail  = 0;
  int tick_no = 0;
  bit count_en = 1'b0;
  int cnt_hs_a, cnt_ha_a, cnt_vs_b, cnt_va_b;
  int fe_ticks[$];

  function automatic int htot(int d);
    return p_ha[d] + p_hfp[d] + p_hs[d] + p_hbp[d];
  endfunction

  function automatic int vtot(int d);
    return p_va[d] + p_vfp[d] + p_vs[d] + p_vbp[d];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, obs, exp, tick_no);
    end
  endtask

  function automatic void model_step(int d, logic rst_n, logic px);
    m_fe[d] = 1'b0;
    if (!rst_n) begin
      m_h[d] = 0;
      m_v[d] = 0;
    end else if (px) begin
      if (m_h[d] == htot(d) - 1) begin
        m_h[d] = 0;
        if (m_v[d] == p_va[d] - 1) m_fe[d] = 1'b1;
        m_v[d] = (m_v[d] + 1) % vtot(d);
      end else begin
        m_h[d] = m_h[d] + 1;
      end
    end
  endfunction

  // {hsync, vsync, haddr_enb, vaddr_enb, frame_en, hidx, vcnt, vidx-if-visible}
  function automatic logic [33:0] exp_vec(int d);
    int  h = m_h[d];
    int  v = m_v[d];
    int  hs0 = p_ha[d] + p_hfp[d];
    int  vs0 = p_va[d] + p_vfp[d];
    logic hs = !((h >= hs0) && (h < hs0 + p_hs[d]));
    logic vs = !((v >= vs0) && (v < vs0 + p_vs[d]));
    logic ha = (h < p_ha[d]);
    logic va = (v < p_va[d]);
    return {hs, vs, ha, va, m_fe[d], 10'(h), 10'(v), va ? 9'(v) : 9'd0};
  endfunction

  task automatic check_all();
    logic [33:0] obs_a, obs_b;
    obs_a = {a_hsync, a_vsync, a_haddr_enb, a_vaddr_enb, a_frame_en, a_hidx, a_vcnt,
             (m_v[0] < p_va[0]) ? a_vidx : 9'd0};
    obs_b = {b_hsync, b_vsync, b_haddr_enb, b_vaddr_enb, b_frame_en, b_hidx, b_vcnt,
             (m_v[1] < p_va[1]) ? b_vidx : 9'd0};
    chk("raster_full", obs_a, exp_vec(0));
    chk("raster_small", obs_b, exp_vec(1));
    if (b_frame_en) chk("fe_pos_small", {b_hidx, b_vcnt}, {10'd0, 10'(p_va[1])});
    if (count_en) begin
      if (!a_hsync)    cnt_hs_a++;
      if (a_haddr_enb) cnt_ha_a++;
      if (!b_vsync)    cnt_vs_b++;
      if (b_vaddr_enb) cnt_va_b++;
      if (b_frame_en)  fe_ticks.push_back(tick_no);
    end
  endtask

  task automatic tick(input logic rst_n, input logic px);
    i_sclr_n = rst_n;
    i_px_clk = px;
    @(posedge clk);
    tick_no++;
    model_step(0, rst_n, px);
    model_step(1, rst_n, px);
    #1;
    check_all();
  endtask

  task automatic clear_counts();
    cnt_hs_a = 0; cnt_ha_a = 0; cnt_vs_b = 0; cnt_va_b = 0;
    fe_ticks.delete();
  endtask

  initial begin
    int base;
    bit found;
    i_sclr_n = 1'b0;
    i_px_clk = 1'b1;
    m_h = '{0, 0}; m_v = '{0, 0}; m_fe = '{0, 0};

    // Reset with the pixel enable held high
    repeat (3) tick(1'b0, 1'b1);
    chk("rst_hidx", a_hidx, 10'd0);
    chk("rst_vcnt", a_vcnt, 10'd0);
    chk("rst_vidx", a_vidx, 9'd0);
    chk("rst_flags", {a_haddr_enb, a_vaddr_enb, a_hsync, a_vsync, a_frame_en}, 5'b11110);

    // Two complete scaled frames at full rate
    clear_counts();
    count_en = 1'b1;
    base = tick_no;
    repeat (2 * htot(1) * vtot(1)) tick(1'b1, 1'b1);
    count_en = 1'b0;
    chk("fe_count", fe_ticks.size(), 2);
    if (fe_ticks.size() >= 2) begin
      chk("fe_first", fe_ticks[0] - base, p_va[1] * htot(1));
      chk("fe_period", fe_ticks[1] - fe_ticks[0], htot(1) * vtot(1));
    end
    chk("vsync_low_cycles", cnt_vs_b, 2 * p_vs[1] * htot(1));
    chk("vis_line_cycles", cnt_va_b, 2 * p_va[1] * htot(1));

    // Twenty full-size lines from reset
    tick(1'b0, 1'b1);
    clear_counts();
    count_en = 1'b1;
    repeat (20 * htot(0)) tick(1'b1, 1'b1);
    count_en = 1'b0;
    chk("hsync_low_cycles", cnt_hs_a, 20 * p_hs[0]);
    chk("hvis_cycles", cnt_ha_a, 20 * p_ha[0]);

    // Quarter-rate pixel enable
    for (int i = 0; i < 4000; i++) tick(1'b1, (i % 4) == 0);

    // Random enable duty with occasional resets
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 499) != 0, $urandom_range(0, 2) != 0);

    // Reset in the middle of a scaled VSYNC (and HSYNC) pulse
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (m_h[1] == p_ha[1] + p_hfp[1] + 2 && m_v[1] == p_va[1] + p_vfp[1] + 1) found = 1'b1;
      else tick(1'b1, 1'b1);
    end
    chk("reach_vsync", found, 1'b1);
    chk("pre_rst_syncs", {b_hsync, b_vsync}, 2'b00);
    tick(1'b0, 1'b1);
    chk("mid_rst_syncs", {b_hsync, b_vsync}, 2'b11);
    chk("mid_rst_pos", {b_hidx, b_vcnt}, 20'd0);
    chk("mid_rst_enb", {b_haddr_enb, b_vaddr_enb}, 2'b11);
    tick(1'b1, 1'b1);
    chk("first_tick_pos", {b_hidx, b_vcnt}, {10'd1, 10'd0});

    // Frame wrap corner on the scaled instance, with hold cycles before the tick
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (m_h[1] == htot(1) - 1 && m_v[1] == vtot(1) - 1) found = 1'b1;
      else tick(1'b1, 1'b1);
    end
    chk("reach_corner", found, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    chk("corner_hold", {b_hidx, b_vcnt, b_vaddr_enb}, {10'(htot(1) - 1), 10'(vtot(1) - 1), 1'b0});
    tick(1'b1, 1'b1);
    chk("corner_wrap", {b_hidx, b_vcnt, b_vaddr_enb, b_frame_en}, {10'd0, 10'd0, 1'b1, 1'b0});
    repeat (50) tick(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
